// File: rtl/eq_mix_engine.sv
// Per-channel band mixer: weighted band sum, clamp, then master volume on one shared multiplier.
// Optional macro EQ_VOL_RAMP_EN: volume ramps toward the captured value by 1 LSB per frame.
module eq_mix_engine #(
  parameter int CH        = 2,
  parameter int NUM_BANDS = 5,
  parameter int DATA_W    = 16,
  parameter int POT_W     = 12
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_vld,
  output logic                           in_rdy,
  input  logic [CH*NUM_BANDS*DATA_W-1:0] band_smpl,
  input  logic [NUM_BANDS*POT_W-1:0]     band_gain,
  input  logic [POT_W-1:0]               vol,
  output logic [CH*DATA_W-1:0]           out_smpl,
  output logic                           out_vld,
  output logic                           sat_flag,
  output logic [7:0]                     drop_cnt
);

  localparam int AW = DATA_W + POT_W + $clog2(NUM_BANDS) + 1;
  localparam int PW = DATA_W + POT_W + 1;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int BW = $clog2(NUM_BANDS);

  typedef enum logic [1:0] {StIdle, StMac, StVol, StDone} state_e;

  state_e                           r_state;
  logic [CH*NUM_BANDS*DATA_W-1:0]   r_smpl;
  logic [NUM_BANDS*POT_W-1:0]       r_gain;
  logic [POT_W-1:0]                 r_vol;
  logic [CW-1:0]                    r_ch;
  logic [BW-1:0]                    r_band;
  logic signed [AW-1:0]             r_acc;
  logic [CH*DATA_W-1:0]             r_res;
  logic                             r_clip;
  logic [7:0]                       r_drop;
  logic [CH*DATA_W-1:0]             r_out;
  logic                             r_out_vld;
  logic                             r_sat;
`ifdef EQ_VOL_RAMP_EN
  logic [POT_W-1:0]                 r_eff_vol;
`endif

  logic signed [DATA_W-1:0] w_smpl_sel;
  logic [POT_W-1:0]         w_gain_sel;
  logic [POT_W-1:0]         w_vol_use;
  logic                     w_fit;
  logic signed [DATA_W-1:0] w_clamped;
  logic signed [DATA_W-1:0] w_mul_a;
  logic signed [POT_W:0]    w_mul_b;
  logic signed [PW-1:0]     w_prod;
  logic signed [AW-1:0]     w_term;
  logic signed [DATA_W-1:0] w_vol_res;

`ifdef EQ_VOL_RAMP_EN
  assign w_vol_use = r_eff_vol;
`else
  assign w_vol_use = r_vol;
`endif

  always_comb begin
    w_smpl_sel = r_smpl[(int'(r_ch) * NUM_BANDS + int'(r_band)) * DATA_W +: DATA_W];
    w_gain_sel = r_gain[int'(r_band) * POT_W +: POT_W];
    // Accumulator fits DATA_W iff all bits above the DATA_W sign bit match it.
    w_fit      = (r_acc[AW-1:DATA_W-1] == {(AW-DATA_W+1){r_acc[AW-1]}});
    if (w_fit) begin
      w_clamped = r_acc[DATA_W-1:0];
    end else if (r_acc[AW-1]) begin
      w_clamped = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      w_clamped = {1'b0, {(DATA_W-1){1'b1}}};
    end
    // Single shared multiplier: band gain in MAC, master volume in VOL.
    if (r_state == StVol) begin
      w_mul_a = w_clamped;
      w_mul_b = {1'b0, w_vol_use};
    end else begin
      w_mul_a = w_smpl_sel;
      w_mul_b = {1'b0, w_gain_sel};
    end
    w_prod    = w_mul_a * w_mul_b;
    w_term    = {{(AW-DATA_W-2){w_prod[PW-1]}}, w_prod[PW-1:POT_W-1]};
    w_vol_res = w_prod[POT_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_smpl    <= '0;
      r_gain    <= '0;
      r_vol     <= '0;
      r_ch      <= '0;
      r_band    <= '0;
      r_acc     <= '0;
      r_res     <= '0;
      r_clip    <= 1'b0;
      r_drop    <= '0;
      r_out     <= '0;
      r_out_vld <= 1'b0;
      r_sat     <= 1'b0;
`ifdef EQ_VOL_RAMP_EN
      r_eff_vol <= '0;
`endif
    end else begin
      r_out_vld <= 1'b0;
      r_sat     <= 1'b0;
      if (in_vld && (r_state != StIdle) && (r_drop != 8'hFF)) begin
        r_drop <= r_drop + 8'd1;
      end
      unique case (r_state)
        StIdle: begin
          if (in_vld) begin
            r_smpl  <= band_smpl;
            r_gain  <= band_gain;
            r_vol   <= vol;
            r_ch    <= '0;
            r_band  <= '0;
            r_acc   <= '0;
            r_clip  <= 1'b0;
            r_state <= StMac;
          end
        end
        StMac: begin
          r_acc <= r_acc + w_term;
          if (r_band == BW'(NUM_BANDS - 1)) begin
            r_band  <= '0;
            r_state <= StVol;
          end else begin
            r_band <= r_band + BW'(1);
          end
        end
        StVol: begin
          if (!w_fit) begin
            r_clip <= 1'b1;
          end
          r_res[int'(r_ch) * DATA_W +: DATA_W] <= w_vol_res;
          r_acc <= '0;
          if (r_ch == CW'(CH - 1)) begin
            r_state <= StDone;
          end else begin
            r_ch    <= r_ch + CW'(1);
            r_state <= StMac;
          end
        end
        StDone: begin
          r_out     <= r_res;
          r_out_vld <= 1'b1;
          r_sat     <= r_clip;
`ifdef EQ_VOL_RAMP_EN
          if (r_eff_vol < r_vol) begin
            r_eff_vol <= r_eff_vol + POT_W'(1);
          end else if (r_eff_vol > r_vol) begin
            r_eff_vol <= r_eff_vol - POT_W'(1);
          end
`endif
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_rdy   = (r_state == StIdle);
  assign out_smpl = r_out;
  assign out_vld  = r_out_vld;
  assign sat_flag = r_sat;
  assign drop_cnt = r_drop;

endmodule

// File: tb/tb_eq_mix_engine.sv
// Randomized scoreboard bench for eq_mix_engine against an arithmetic reference model.
module tb_eq_mix_engine;
  localparam int CH  = 2;
  localparam int NB  = 5;
  localparam int DW  = 16;
  localparam int PW  = 12;
  localparam int LAT = CH * (NB + 1) + 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_vld = 1'b0;
  logic                   in_rdy;
  logic [CH*NB*DW-1:0]    band_smpl = '0;
  logic [NB*PW-1:0]       band_gain = '0;
  logic [PW-1:0]          vol = '0;
  logic [CH*DW-1:0]       out_smpl;
  logic                   out_vld;
  logic                   sat_flag;
  logic [7:0]             drop_cnt;

  int total = 0;
  int bad   = 0;

  logic [CH*DW-1:0] q_out[$];
  logic             q_sat[$];
  time              q_t[$];
  logic [CH*DW-1:0] last_out = '0;
  logic [CH*DW-1:0] mon_e;
  logic             mon_s;
  time              mon_t;
  int               m_busy = 0;
  int               m_drop = 0;
  logic [PW-1:0]    m_eff = '0;

  always #5 clk = ~clk;

  eq_mix_engine #(.CH(CH), .NUM_BANDS(NB), .DATA_W(DW), .POT_W(PW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .band_smpl(band_smpl),
    .band_gain(band_gain),
    .vol      (vol),
    .out_smpl (out_smpl),
    .out_vld  (out_vld),
    .sat_flag (sat_flag),
    .drop_cnt (drop_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Floor-division arithmetic on plain integers, straight from the mixing rules.
  function automatic void ref_frame(output logic [CH*DW-1:0] o, output logic sat);
    longint acc, sm, gg, v, res, hi, lo;
    hi  = (longint'(1) <<< (DW - 1)) - 1;
    lo  = -(longint'(1) <<< (DW - 1));
    sat = 1'b0;
    o   = '0;
`ifdef EQ_VOL_RAMP_EN
    v = longint'(m_eff);
`else
    v = longint'(vol);
`endif
    for (int c = 0; c < CH; c++) begin
      acc = 0;
      for (int b = 0; b < NB; b++) begin
        sm  = $signed(band_smpl[(c*NB+b)*DW +: DW]);
        gg  = longint'(band_gain[b*PW +: PW]);
        acc = acc + ((sm * gg) >>> (PW - 1));
      end
      if (acc > hi) begin acc = hi; sat = 1'b1; end
      if (acc < lo) begin acc = lo; sat = 1'b1; end
      res = (acc * v) >>> PW;
      o[c*DW +: DW] = res[DW-1:0];
    end
  endfunction

  task automatic cycle(input logic v);
    logic [CH*DW-1:0] e;
    logic             s;
    in_vld = v;
    chk("in_rdy", 64'(in_rdy), 64'(m_busy == 0));
    @(posedge clk);
    if (m_busy > 0) begin
      if (v && m_drop < 255) m_drop++;
      m_busy--;
    end else if (v) begin
      ref_frame(e, s);
      q_out.push_back(e);
      q_sat.push_back(s);
      q_t.push_back($time);
      if (m_eff < vol) m_eff = m_eff + 1'b1;
      else if (m_eff > vol) m_eff = m_eff - 1'b1;
      m_busy = LAT;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic set_all(input logic [DW-1:0] s, input logic [PW-1:0] g, input logic [PW-1:0] v);
    for (int i = 0; i < CH*NB; i++) band_smpl[i*DW +: DW] = s;
    for (int i = 0; i < NB; i++) band_gain[i*PW +: PW] = g;
    vol = v;
  endtask

  task automatic rnd();
    for (int i = 0; i < CH*NB; i++) begin
      case ($urandom_range(0, 5))
        0:       band_smpl[i*DW +: DW] = 16'h7FFF;
        1:       band_smpl[i*DW +: DW] = 16'h8000;
        default: band_smpl[i*DW +: DW] = DW'($urandom);
      endcase
    end
    for (int i = 0; i < NB; i++) begin
      case ($urandom_range(0, 5))
        0:       band_gain[i*PW +: PW] = '0;
        1:       band_gain[i*PW +: PW] = 12'h800;
        2:       band_gain[i*PW +: PW] = 12'hFFF;
        default: band_gain[i*PW +: PW] = PW'($urandom);
      endcase
    end
    case ($urandom_range(0, 4))
      0:       vol = '0;
      1:       vol = 12'hFFF;
      default: vol = PW'($urandom);
    endcase
  endtask

  task automatic drain();
    int k = 0;
    in_vld = 1'b0;
    while ((m_busy > 0 || q_out.size() > 0) && k < 200) begin
      cycle(1'b0);
      k++;
    end
    if (k >= 200) chk("drain timeout pending", 64'(q_out.size()), 64'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_vld = 1'b0;
    q_out.delete();
    q_sat.delete();
    q_t.delete();
    m_busy   = 0;
    m_drop   = 0;
    m_eff    = '0;
    last_out = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset out_smpl", 64'(out_smpl), 64'(0));
    chk("reset out_vld", 64'(out_vld), 64'(0));
    chk("reset sat_flag", 64'(sat_flag), 64'(0));
    chk("reset drop_cnt", 64'(drop_cnt), 64'(0));
    rst_n = 1'b1;
    chk("in_rdy after reset", 64'(in_rdy), 64'(1));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_vld) begin
        if (q_out.size() == 0) begin
          chk("out_vld with empty scoreboard", 64'(out_vld), 64'(0));
        end else begin
          mon_e = q_out.pop_front();
          mon_s = q_sat.pop_front();
          mon_t = q_t.pop_front();
          chk("out_smpl", 64'(out_smpl), 64'(mon_e));
          chk("sat_flag", 64'(sat_flag), 64'(mon_s));
          chk("latency", 64'($time - mon_t), 64'(LAT * 10 + 5));
          last_out = mon_e;
        end
      end else begin
        chk("out_smpl hold", 64'(out_smpl), 64'(last_out));
        chk("sat_flag idle", 64'(sat_flag), 64'(0));
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    do_reset();

    set_all(16'd200, 12'h800, 12'hFFF);
    cycle(1'b1);
    drain();
`ifndef EQ_VOL_RAMP_EN
    chk("bands 200 ch0", 64'(out_smpl[15:0]), 64'(16'd999));
    chk("bands 200 ch1", 64'(out_smpl[31:16]), 64'(16'd999));
`endif
    set_all(-16'sd200, 12'h800, 12'hFFF);
    cycle(1'b1);
    drain();
`ifndef EQ_VOL_RAMP_EN
    chk("bands -200 ch0", 64'(out_smpl[15:0]), 64'(16'hFC18));
    chk("bands -200 ch1", 64'(out_smpl[31:16]), 64'(16'hFC18));
`endif
    set_all(16'h7000, 12'h800, 12'hFFF);
    cycle(1'b1);
    drain();
`ifndef EQ_VOL_RAMP_EN
    chk("clip ch0", 64'(out_smpl[15:0]), 64'(16'h7FF7));
    chk("clip ch1", 64'(out_smpl[31:16]), 64'(16'h7FF7));
`endif
    set_all(16'h1234, 12'h000, 12'hFFF);
    cycle(1'b1);
    drain();
    chk("zero gain", 64'(out_smpl), 64'(0));
    set_all(16'h9000, 12'h800, 12'h000);
    cycle(1'b1);
    drain();
    chk("zero vol", 64'(out_smpl), 64'(0));

    // Back-to-back valid: one accepted, the rest counted as drops.
    rnd();
    repeat (LAT) cycle(1'b1);
    cycle(1'b0);
    chk("drop_cnt burst", 64'(drop_cnt), 64'(m_drop));
    chk("drop_cnt burst is 12", 64'(drop_cnt), 64'(12));
    rnd();
    cycle(1'b1);
    drain();

    // Reset mid-frame discards the in-flight frame.
    rnd();
    cycle(1'b1);
    repeat (5) cycle(1'b0);
    do_reset();
    rnd();
    cycle(1'b1);
    drain();

    repeat (400) begin
      rnd();
      cycle(1'($urandom_range(0, 1)));
    end
    drain();

    repeat (300) begin
      rnd();
      cycle(1'b1);
    end
    drain();
    chk("drop_cnt model", 64'(drop_cnt), 64'(m_drop));
    chk("drop_cnt saturated", 64'(drop_cnt), 64'(255));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/eq_mix_engine.md
EQ_MIX_ENGINE -- requirements
Module: eq_mix_engine

Interface
REQ-001 SHALL provide parameter CH, default 2, number of audio channels (>=1).
REQ-002 SHALL provide parameter NUM_BANDS, default 5, number of filter bands per channel (>=2).
REQ-003 SHALL provide parameter DATA_W, default 16, signed sample width.
REQ-004 SHALL provide parameter POT_W, default 12, unsigned gain/volume width.
REQ-005 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port in_vld  input  1  band-sample set valid.
REQ-008 SHALL have port in_rdy  output  1  engine idle, set accepted this cycle if in_vld.
REQ-009 SHALL have port band_smpl  input  CH*NUM_BANDS*DATA_W  signed band outputs, channel c band b at index (c*NUM_BANDS+b).
REQ-010 SHALL have port band_gain  input  NUM_BANDS*POT_W  unsigned per-band gain, shared by all channels.
REQ-011 SHALL have port vol  input  POT_W  unsigned master volume.
REQ-012 SHALL have port out_smpl  output  CH*DATA_W  signed mixed output, channel c at slice c.
REQ-013 SHALL have port out_vld  output  1  one-cycle pulse, out_smpl updated.
REQ-014 SHALL have port sat_flag  output  1  valid with out_vld; 1 if any channel clipped this frame.
REQ-015 SHALL have port drop_cnt  output  8  saturating count of in_vld cycles with in_rdy=0.

Function
REQ-016 SHALL capture band_smpl, band_gain and vol into internal registers on the cycle in_vld && in_rdy; later input changes SHALL not affect that frame.
REQ-017 SHALL use a single shared signed multiplier, time-multiplexed by an FSM with states IDLE, MAC, VOL, DONE.
REQ-018 IDLE: in_rdy=1; capture -> MAC with channel=0, band=0, accumulator=0.
REQ-019 MAC: one band per cycle, acc += (smpl*gain) >>> (POT_W-1) (arithmetic shift, gain 2^(POT_W-1) = unity); after band NUM_BANDS-1 -> VOL.
REQ-020 Accumulator width SHALL be DATA_W+POT_W+clog2(NUM_BANDS)+1 so no internal overflow occurs.
REQ-021 VOL: clamp acc to [-2^(DATA_W-1), 2^(DATA_W-1)-1], set per-frame clip bit if clamped, compute (clamped*vol) >>> POT_W, store to channel slot; if last channel -> DONE else next channel, MAC.
REQ-022 DONE: drive all channel results onto out_smpl, pulse out_vld and sat_flag for exactly one cycle, -> IDLE.
REQ-023 Latency SHALL be CH*(NUM_BANDS+1)+1 cycles from capture edge to out_vld (13 at defaults).
REQ-024 in_rdy SHALL be 0 in MAC, VOL, DONE; in_vld in those states SHALL be ignored and increment drop_cnt, holding at 255.
REQ-025 out_smpl SHALL hold its value between out_vld pulses; sat_flag SHALL be 0 outside out_vld.
REQ-026 Gain 0 on all bands SHALL yield out_smpl 0; vol 0 SHALL yield 0.

Reset
REQ-027 On rst_n low, at any time including mid-frame, FSM SHALL go to IDLE, the in-flight frame SHALL be discarded, and out_smpl, out_vld, sat_flag, drop_cnt, accumulator and counters SHALL be 0.
REQ-028 in_rdy SHALL be 1 on the first cycle after rst_n deasserts.

Configuration
REQ-029 Macro EQ_VOL_RAMP_EN defined: an effective-volume register (reset 0) SHALL step by 1 LSB toward captured vol once per frame in DONE, and VOL state SHALL use the effective volume of the current frame.
REQ-030 Macro EQ_VOL_RAMP_EN undefined: VOL state SHALL use captured vol directly; no ramp register exists.

Verification (defaults, EQ_VOL_RAMP_EN undefined)
REQ-031 All bands 200, gains 0x800, vol 0xFFF -> out_vld 13 cycles after capture, both channels 999, sat_flag 0.
REQ-032 All bands -200, gains 0x800, vol 0xFFF -> both channels -1000 (floor), sat_flag 0.
REQ-033 All bands 0x7000, gains 0x800, vol 0xFFF -> both channels 32759, sat_flag 1.
REQ-034 in_vld held 13 cycles back-to-back -> one frame accepted, drop_cnt 12, next in_vld after out_vld accepted.
REQ-035 rst_n pulsed low 5 cycles after capture -> no out_vld, out_smpl 0, in_rdy 1 after release; new frame completes normally.
REQ-036 EQ_VOL_RAMP_EN defined, vol 0xFFF, bands 200, gains 0x800 -> first frame output 0, second 0 (eff vol 1: 1000*1>>12), volume rising 1 LSB per frame.
